// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC I/O / memory target: FSM states,
// CYCTYPE direction field codes and the nibble codes the target drives.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CYCTYPE = 4'd1,
    ST_ADDR    = 4'd2,
    ST_DATA    = 4'd3,
    ST_HTAR1   = 4'd4,
    ST_HTAR2   = 4'd5,
    ST_SWAIT   = 4'd6,
    ST_SRDY    = 4'd7,
    ST_SERR    = 4'd8,
    ST_RD0     = 4'd9,
    ST_RD1     = 4'd10,
    ST_PTAR1   = 4'd11,
    ST_PTAR2   = 4'd12
  } lpc_state_e;

  // CYCTYPE lad[3:2]
  localparam logic [1:0] CYC_IO  = 2'b00;
  localparam logic [1:0] CYC_MEM = 2'b01;

  // Nibble codes
  localparam logic [3:0] LAD_START  = 4'b0000;
  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERROR = 4'b1010;
  localparam logic [3:0] LAD_TAR    = 4'b1111;

endpackage

// File: rtl/lpc_nibble_shifter.sv
// MSB-first nibble shift register with a nibble counter; used for the
// address field and then, after a clear, for the write data byte.
module lpc_nibble_shifter #(
  parameter int W = 28
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic [3:0]   nib_i,
  output logic [W-1:0] data_o,
  output logic [3:0]   cnt_o
);

  logic [W-1:0] data_q, data_d;
  logic [3:0]   cnt_q, cnt_d;

  // Next-state: clear wins over shift
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = 4'd0;
    end else if (shift_i) begin
      data_d = {data_q[W-5:0], nib_i};
      cnt_d  = cnt_q + 4'd1;
    end
  end

  // Nibble counter is control state and is reset
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  // Shift data is only meaningful after a clear, so it carries no reset
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/lpc_io_target.sv
// LPC target for I/O and memory cycles: decodes START/CYCTYPE/ADDR/DATA,
// hands the access to a simple req/ack backend, answers with SYNC codes,
// returns read data and performs the peripheral turnaround.
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] IO_BASE      = 16'h0000,
  parameter logic [15:0] IO_MASK      = 16'hFF00,
  parameter logic [31:0] MEM_BASE     = 32'hFED4_0000,
  parameter logic [31:0] MEM_MASK     = 32'hFFFF_0000,
  parameter logic [7:0]  SYNC_TIMEOUT = 8'd32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lframe_i,
  input  logic [3:0]  lad_i,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  output logic        req_o,
  output logic        we_o,
  output logic        mem_o,
  output logic [31:0] addr_o,
  output logic [7:0]  wdata_o,
  input  logic [7:0]  rdata_i,
  input  logic        ack_i,
  output logic [3:0]  state_o
);

  lpc_state_e  state_q;
  logic [3:0]  lad_q;
  logic        lad_oe_q, req_q, we_q, mem_q, hit_q, acked_q;
  logic [31:0] addr_q;
  logic [7:0]  wdata_q, rdata_q, tmo_q;

  logic [27:0] sh_data;
  logic [3:0]  sh_cnt;
  logic        sh_clr, sh_en;
  logic        addr_last, data_last, hit;
  logic [31:0] full_addr;
  logic        ack_now, acked_now;
  lpc_state_e  sync_state_d;
  logic [3:0]  sync_lad_d;
  logic [7:0]  tmo_d;

  lpc_nibble_shifter #(.W(28)) u_shift (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (sh_clr),
    .shift_i (sh_en),
    .nib_i   (lad_i),
    .data_o  (sh_data),
    .cnt_o   (sh_cnt)
  );

  // Field framing and address decode, including the nibble on the bus now
  always_comb begin
    addr_last = (sh_cnt == (mem_q ? 4'd7 : 4'd3));
    data_last = (sh_cnt == 4'd1);
    full_addr = mem_q ? {sh_data[27:0], lad_i} : {16'h0000, sh_data[11:0], lad_i};
    if (mem_q) hit = ((full_addr & MEM_MASK) == (MEM_BASE & MEM_MASK));
    else       hit = ((full_addr[15:0] & IO_MASK) == (IO_BASE & IO_MASK));
    sh_clr = (state_q == ST_CYCTYPE) || ((state_q == ST_ADDR) && addr_last);
    sh_en  = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && lframe_i && !sh_clr;
  end

  // Choice of the next SYNC nibble: ready once acked, error after the wait budget
  always_comb begin
    ack_now      = req_q && ack_i;
    acked_now    = acked_q || ack_now;
    sync_state_d = ST_SWAIT;
    sync_lad_d   = SYNC_LWAIT;
    tmo_d        = tmo_q + 8'd1;
    if (acked_now) begin
      sync_state_d = ST_SRDY;
      sync_lad_d   = SYNC_READY;
      tmo_d        = 8'd0;
    end else if (tmo_q >= SYNC_TIMEOUT) begin
      sync_state_d = ST_SERR;
      sync_lad_d   = SYNC_ERROR;
      tmo_d        = tmo_q;
    end
  end

  // Cycle FSM with registered bus and backend outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      lad_q    <= 4'h0;
      lad_oe_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      mem_q    <= 1'b0;
      hit_q    <= 1'b0;
      acked_q  <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      tmo_q    <= 8'h00;
    end else begin
      if (ack_now) begin
        req_q   <= 1'b0;
        acked_q <= 1'b1;
        rdata_q <= rdata_i;
      end
      if ((state_q != ST_IDLE) && !lframe_i) begin
        // Abort: release everything, then treat this clock as a START candidate
        lad_oe_q <= 1'b0;
        lad_q    <= 4'h0;
        req_q    <= 1'b0;
        acked_q  <= 1'b0;
        tmo_q    <= 8'h00;
        state_q  <= (lad_i == LAD_START) ? ST_CYCTYPE : ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!lframe_i && (lad_i == LAD_START)) begin
              state_q <= ST_CYCTYPE;
              acked_q <= 1'b0;
              tmo_q   <= 8'h00;
            end
          end
          ST_CYCTYPE: begin
            if ((lad_i[3:2] == CYC_IO) || (lad_i[3:2] == CYC_MEM)) begin
              we_q    <= lad_i[1];
              mem_q   <= lad_i[2];
              state_q <= ST_ADDR;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_ADDR: begin
            if (addr_last) begin
              addr_q <= full_addr;
              if (we_q) begin
                hit_q   <= hit;
                state_q <= ST_DATA;
              end else if (hit) begin
                req_q   <= 1'b1;
                state_q <= ST_HTAR1;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_DATA: begin
            if (data_last) begin
              wdata_q <= {lad_i, sh_data[3:0]};
              if (hit_q) begin
                req_q   <= 1'b1;
                state_q <= ST_HTAR1;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_HTAR1: state_q <= ST_HTAR2;
          ST_HTAR2, ST_SWAIT: begin
            state_q  <= sync_state_d;
            lad_q    <= sync_lad_d;
            lad_oe_q <= 1'b1;
            tmo_q    <= tmo_d;
            if (sync_state_d == ST_SERR) req_q <= 1'b0;
          end
          ST_SRDY: begin
            if (!we_q) begin
              state_q <= ST_RD0;
              lad_q   <= rdata_q[3:0];
            end else begin
              state_q <= ST_PTAR1;
              lad_q   <= LAD_TAR;
            end
          end
          ST_SERR: begin
            state_q <= ST_PTAR1;
            lad_q   <= LAD_TAR;
          end
          ST_RD0: begin
            state_q <= ST_RD1;
            lad_q   <= rdata_q[7:4];
          end
          ST_RD1: begin
            state_q <= ST_PTAR1;
            lad_q   <= LAD_TAR;
          end
          ST_PTAR1: begin
            state_q  <= ST_PTAR2;
            lad_oe_q <= 1'b0;
            lad_q    <= 4'h0;
          end
          ST_PTAR2: state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign lad_o    = lad_q;
  assign lad_oe_o = lad_oe_q;
  assign req_o    = req_q;
  assign we_o     = we_q;
  assign mem_o    = mem_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed bench for lpc_io_target: host-side LPC cycles with a simple
// backend responder, checked against hand-computed bus and backend values.
module tb_lpc_io_target;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lframe_i;
  logic [3:0]  lad_i;
  logic [3:0]  lad_o;
  logic        lad_oe_o;
  logic        req_o;
  logic        we_o;
  logic        mem_o;
  logic [31:0] addr_o;
  logic [7:0]  wdata_o;
  logic [7:0]  rdata_i;
  logic        ack_i;
  logic [3:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;
  bit oe_any, req_any;

  lpc_io_target dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .lframe_i (lframe_i),
    .lad_i    (lad_i),
    .lad_o    (lad_o),
    .lad_oe_o (lad_oe_o),
    .req_o    (req_o),
    .we_o     (we_o),
    .mem_o    (mem_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .rdata_i  (rdata_i),
    .ack_i    (ack_i),
    .state_o  (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One LPC clock: at the falling edge drive the host nibble; outputs seen
  // after this call belong to the same clock.
  task automatic cyc(input logic lf, input logic [3:0] nib);
    @(negedge clk_i);
    lframe_i = lf;
    lad_i    = nib;
    oe_any   = oe_any | lad_oe_o;
    req_any  = req_any | req_o;
  endtask

  task automatic send_header(input bit mem, input bit wr, input logic [31:0] a,
                             input logic [7:0] wd, input bit do_start);
    if (do_start) cyc(1'b0, 4'h0);
    cyc(1'b1, {1'b0, mem, wr, 1'b0});
    for (int i = (mem ? 7 : 3); i >= 0; i--) cyc(1'b1, a[4*i +: 4]);
    if (wr) begin
      cyc(1'b1, wd[3:0]);
      cyc(1'b1, wd[7:4]);
    end
  endtask

  task automatic lpc_cycle(input bit mem, input bit wr, input logic [31:0] a,
                           input logic [7:0] wd, input logic [7:0] rd, input bit hit,
                           input int nwait, input bit tmo, input bit do_start);
    int  waits;
    oe_any  = 1'b0;
    req_any = 1'b0;
    rdata_i = rd;
    send_header(mem, wr, a, wd, do_start);
    cyc(1'b1, 4'hF);                         // host TAR 1
    if (!hit) begin
      for (int k = 0; k < 6; k++) cyc(1'b1, 4'hF);
      check_eq("miss_req_never", {31'd0, req_any}, 32'd0);
      check_eq("miss_oe_never", {31'd0, oe_any}, 32'd0);
      check_eq("miss_state_idle", {28'd0, state_o}, 32'd0);
    end else begin
      check_eq("req_in_htar1", {31'd0, req_o}, 32'd1);
      check_eq("we", {31'd0, we_o}, {31'd0, wr});
      check_eq("mem", {31'd0, mem_o}, {31'd0, mem});
      check_eq("addr", addr_o, mem ? a : {16'h0000, a[15:0]});
      if (wr) check_eq("wdata", {24'd0, wdata_o}, {24'd0, wd});
      ack_i = (nwait == 0) && !tmo;
      cyc(1'b1, 4'hF);                       // host TAR 2
      ack_i = 1'b0;
      check_eq("htar_no_drive", {31'd0, oe_any}, 32'd0);
      waits = 0;
      for (int k = 0; k < 80; k++) begin
        cyc(1'b1, 4'hF);
        ack_i = 1'b0;
        if (lad_oe_o && (lad_o == 4'b0110)) begin
          waits++;
          if (!tmo && (waits == nwait)) ack_i = 1'b1;
        end else begin
          break;
        end
      end
      check_eq("lwait_count", waits, tmo ? 32'd32 : nwait);
      check_eq("sync_final", {27'd0, lad_oe_o, lad_o}, tmo ? 32'h1A : 32'h10);
      check_eq("req_dropped", {31'd0, req_o}, 32'd0);
      if (!wr && !tmo) begin
        cyc(1'b1, 4'hF);
        check_eq("rdata_lo", {27'd0, lad_oe_o, lad_o}, {27'd0, 1'b1, rd[3:0]});
        cyc(1'b1, 4'hF);
        check_eq("rdata_hi", {27'd0, lad_oe_o, lad_o}, {27'd0, 1'b1, rd[7:4]});
      end
      cyc(1'b1, 4'hF);
      check_eq("ptar_drive", {27'd0, lad_oe_o, lad_o}, 32'h1F);
      if (tmo) ack_i = 1'b1;                 // late ack must be ignored
      cyc(1'b1, 4'hF);
      ack_i = 1'b0;
      check_eq("ptar_release", {31'd0, lad_oe_o}, 32'd0);
      check_eq("ptar_req_low", {31'd0, req_o}, 32'd0);
      cyc(1'b1, 4'hF);
      check_eq("back_to_idle", {28'd0, state_o}, 32'd0);
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    lframe_i = 1'b1;
    lad_i    = 4'hF;
    ack_i    = 1'b0;
    rdata_i  = 8'h00;
    oe_any   = 1'b0;
    req_any  = 1'b0;
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'hF);
    check_eq("rst_oe", {31'd0, lad_oe_o}, 32'd0);
    check_eq("rst_lad", {28'd0, lad_o}, 32'd0);
    check_eq("rst_req_we_mem", {29'd0, req_o, we_o, mem_o}, 32'd0);
    check_eq("rst_addr", addr_o, 32'd0);
    check_eq("rst_wdata", {24'd0, wdata_o}, 32'd0);
    check_eq("rst_state", {28'd0, state_o}, 32'd0);
    rst_i = 1'b0;
    cyc(1'b1, 4'hF);

    // I/O write 0x0042 <- 0x5A, one long wait
    lpc_cycle(1'b0, 1'b1, 32'h0000_0042, 8'h5A, 8'h00, 1'b1, 1, 1'b0, 1'b1);
    // I/O read 0x0080 -> 0xA5, three long waits
    lpc_cycle(1'b0, 1'b0, 32'h0000_0080, 8'h00, 8'hA5, 1'b1, 3, 1'b0, 1'b1);
    // Memory read 0xFED40010 -> 0x3C, immediate ack
    lpc_cycle(1'b1, 1'b0, 32'hFED4_0010, 8'h00, 8'h3C, 1'b1, 0, 1'b0, 1'b1);
    // I/O write 0x1234 misses the decode window
    lpc_cycle(1'b0, 1'b1, 32'h0000_1234, 8'h99, 8'h00, 1'b0, 0, 1'b0, 1'b1);
    // Read with no ack at all: timeout
    lpc_cycle(1'b0, 1'b0, 32'h0000_0011, 8'h00, 8'h5C, 1'b1, 0, 1'b1, 1'b1);

    // Abort during third address nibble, then a fresh cycle
    oe_any  = 1'b0;
    req_any = 1'b0;
    cyc(1'b0, 4'h0);
    cyc(1'b1, 4'h2);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    cyc(1'b0, 4'hF);
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'hF);
    check_eq("abort_no_drive", {30'd0, oe_any, req_any}, 32'd0);
    check_eq("abort_idle", {28'd0, state_o}, 32'd0);
    lpc_cycle(1'b0, 1'b1, 32'h0000_00C3, 8'h3C, 8'h00, 1'b1, 2, 1'b0, 1'b1);

    // Abort whose lframe clock is itself a START: cycle continues at CYCTYPE
    cyc(1'b0, 4'h0);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    cyc(1'b0, 4'h0);
    lpc_cycle(1'b0, 1'b0, 32'h0000_0055, 8'h00, 8'h69, 1'b1, 1, 1'b0, 1'b0);

    // Reset in the middle of SYNC, together with ack and an abort START
    rdata_i = 8'hEE;
    send_header(1'b1, 1'b1, 32'hFED4_0010, 8'h77, 1'b1);
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'hF);
    check_eq("pre_rst_sync", {27'd0, lad_oe_o, lad_o}, 32'h16);
    rst_i    = 1'b1;
    ack_i    = 1'b1;
    lframe_i = 1'b0;
    lad_i    = 4'h0;
    @(negedge clk_i);
    check_eq("mid_rst_oe_lad", {27'd0, lad_oe_o, lad_o}, 32'd0);
    check_eq("mid_rst_ctl", {29'd0, req_o, we_o, mem_o}, 32'd0);
    check_eq("mid_rst_addr", addr_o, 32'd0);
    check_eq("mid_rst_wdata", {24'd0, wdata_o}, 32'd0);
    check_eq("mid_rst_state", {28'd0, state_o}, 32'd0);
    rst_i    = 1'b0;
    ack_i    = 1'b0;
    lframe_i = 1'b1;
    lad_i    = 4'hF;
    cyc(1'b1, 4'hF);
    check_eq("post_rst_release", {27'd0, lad_oe_o, req_o, state_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
